// File: rtl/phrase_sequencer_pkg.sv
// Shared widths and FSM state encoding for the phrase sequencer.
// Pure declarations; no timing or flow-control behaviour.
package phrase_sequencer_pkg;

  localparam int ROW_W    = 4;
  localparam int CHANNELS = 4;
  localparam int TEMPO_W  = 8;
  localparam int ACC_W    = 34;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE    = 2'd0;
  localparam seq_state_t ST_PLAYING = 2'd1;
  localparam seq_state_t ST_PAUSED  = 2'd2;
  localparam seq_state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/phrase_sequencer_if.sv
// Control and playback signals between the control front end and the sequencer.
// Level/pulse signalling only: no backpressure, consumers must take every pulse.
interface phrase_sequencer_if;
  import phrase_sequencer_pkg::*;

  logic                play_enable;
  logic                loop_enable;
  logic                restart;
  logic [TEMPO_W-1:0]  tempo;
  logic [ROW_W-1:0]    last_row;
  logic [CHANNELS-1:0] note_present;

  logic [ROW_W-1:0]    row;
  logic                row_tick;
  logic [CHANNELS-1:0] note_trigger;
  logic                playing;
  logic                phrase_done;

  modport master (
    output play_enable, loop_enable, restart, tempo, last_row, note_present,
    input  row, row_tick, note_trigger, playing, phrase_done
  );

  modport slave (
    input  play_enable, loop_enable, restart, tempo, last_row, note_present,
    output row, row_tick, note_trigger, playing, phrase_done
  );

endinterface

// File: rtl/phrase_sequencer_tick_gen.sv
// Phase accumulator turning BPM into row steps; step is combinational, acc updates on the same edge.
// No backpressure: run gates accumulation, clear zeroes the phase.
module phrase_sequencer_tick_gen
  import phrase_sequencer_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROWS_PER_BEAT = 4
) (
  input  logic               clk,
  input  logic               rst_active_low,
  input  logic               run,
  input  logic               clear,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               step
);

  // Threshold is clocks-per-minute; adding rows-per-minute each clock gives an exact long-term rate.
  localparam logic [ACC_W-1:0] TICK_TH = ACC_W'(longint'(CLK_HZ) * 64'sd60);
  localparam logic [ACC_W-1:0] RPB     = ACC_W'(ROWS_PER_BEAT);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             wrap;
  logic             active;

  assign active = run && (tempo != '0);
  assign sum    = acc + ({{(ACC_W-TEMPO_W){1'b0}}, tempo} * RPB);
  assign wrap   = (sum >= TICK_TH);
  assign step   = active && wrap;

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (active) begin
      acc <= wrap ? (sum - TICK_TH) : sum;
    end
  end

endmodule

// File: rtl/phrase_sequencer.sv
// Phrase row scheduler: play/pause/loop/restart FSM, row counter and per-channel note triggers.
// Row/row_tick register on the step edge, note_trigger one cycle later; no backpressure.
module phrase_sequencer
  import phrase_sequencer_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROWS_PER_BEAT = 4
) (
  input  logic               clk,
  input  logic               rst_active_low,
  phrase_sequencer_if.slave  bus
);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    row_nxt;
  logic                tick_nxt;
  logic                done_nxt;
  logic                row_tick_q;
  logic                done_q;
  logic [CHANNELS-1:0] trig_q;
  logic                run;
  logic                clear;
  logic                step;

  // Restart and pause both pre-empt the step, so the accumulator only runs on a clean playing cycle.
  assign run   = (state == ST_PLAYING) && bus.play_enable && !bus.restart;
  assign clear = ((state == ST_IDLE) && bus.play_enable) || ((state != ST_IDLE) && bus.restart);

  phrase_sequencer_tick_gen #(
    .CLK_HZ        (CLK_HZ),
    .ROWS_PER_BEAT (ROWS_PER_BEAT)
  ) u_tick_gen (
    .clk            (clk),
    .rst_active_low (rst_active_low),
    .run            (run),
    .clear          (clear),
    .tempo          (bus.tempo),
    .step           (step)
  );

  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.play_enable) begin
          state_nxt = ST_PLAYING;
          row_nxt   = '0;
          tick_nxt  = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (bus.restart) begin
          row_nxt = '0;
          if (bus.play_enable) tick_nxt  = 1'b1;
          else                 state_nxt = ST_PAUSED;
        end else if (!bus.play_enable) begin
          state_nxt = ST_PAUSED;
        end else if (step) begin
          if (row_q < bus.last_row) begin
            row_nxt  = row_q + ROW_W'(1);
            tick_nxt = 1'b1;
          end else if (bus.loop_enable) begin
            row_nxt  = '0;
            tick_nxt = 1'b1;
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (bus.restart)     row_nxt   = '0;
        if (bus.play_enable) state_nxt = ST_PLAYING;
      end
      ST_DONE: begin
        if (bus.restart) begin
          row_nxt = '0;
          if (bus.play_enable) begin
            state_nxt = ST_PLAYING;
            tick_nxt  = 1'b1;
          end else begin
            state_nxt = ST_PAUSED;
          end
        end else if (!bus.play_enable) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_active_low) begin
    if (!rst_active_low) begin
      state      <= ST_IDLE;
      row_q      <= '0;
      row_tick_q <= 1'b0;
      done_q     <= 1'b0;
      trig_q     <= '0;
    end else begin
      state      <= state_nxt;
      row_q      <= row_nxt;
      row_tick_q <= tick_nxt;
      done_q     <= done_nxt;
      // Notes for the row just entered are dropped if playback stops before they sound.
      trig_q     <= (row_tick_q && (state_nxt == ST_PLAYING)) ? bus.note_present : '0;
    end
  end

  assign bus.row          = row_q;
  assign bus.row_tick     = row_tick_q;
  assign bus.phrase_done  = done_q;
  assign bus.note_trigger = trig_q;
  assign bus.playing      = (state == ST_PLAYING);

endmodule

// File: tb/tb_phrase_sequencer.sv
// Randomised bench for phrase_sequencer: a behavioural model predicts pulses into queues,
// an independent monitor pops and compares them whenever the DUT pulses.
module tb_phrase_sequencer;

  localparam int     CLK_HZ = 1000;
  localparam int     RPB    = 4;
  localparam longint TH     = 60000;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t tick_q[$];
  ev_t done_q[$];
  ev_t trig_q[$];
  ev_t mon_ev;

  int     m_st;
  int     m_row;
  longint m_acc;
  bit     m_show;

  logic [7:0] tempos [5];

  phrase_sequencer_if bus();

  phrase_sequencer #(
    .CLK_HZ        (CLK_HZ),
    .ROWS_PER_BEAT (RPB)
  ) dut (
    .clk            (clk),
    .rst_active_low (rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.cyc = cyc + 1;
    e.val = val;
    if (kind == 0)      tick_q.push_back(e);
    else if (kind == 1) done_q.push_back(e);
    else                trig_q.push_back(e);
  endtask

  task automatic model_reset();
    m_st   = M_IDLE;
    m_row  = 0;
    m_acc  = 0;
    m_show = 0;
    tick_q.delete();
    done_q.delete();
    trig_q.delete();
  endtask

  // Predicts what the next rising edge produces from the inputs currently driven.
  task automatic model_edge();
    bit tick;
    bit done;
    int ns;
    tick = 0;
    done = 0;
    ns   = m_st;
    if (m_st == M_IDLE) begin
      if (bus.play_enable) begin
        ns = M_PLAY; m_row = 0; m_acc = 0; tick = 1;
      end
    end else if (bus.restart) begin
      m_row = 0;
      m_acc = 0;
      if (m_st == M_PAUSE)   ns = bus.play_enable ? M_PLAY : M_PAUSE;
      else if (bus.play_enable) begin ns = M_PLAY; tick = 1; end
      else                   ns = M_PAUSE;
    end else if (m_st == M_PLAY) begin
      if (!bus.play_enable) ns = M_PAUSE;
      else if (bus.tempo != 0) begin
        m_acc += longint'(bus.tempo) * RPB;
        if (m_acc >= TH) begin
          m_acc -= TH;
          if (m_row < int'(bus.last_row)) begin
            m_row++; tick = 1;
          end else begin
            done = 1;
            if (bus.loop_enable) begin m_row = 0; tick = 1; end
            else ns = M_DONE;
          end
        end
      end
    end else if (m_st == M_PAUSE) begin
      if (bus.play_enable) ns = M_PLAY;
    end else begin
      if (!bus.play_enable) ns = M_IDLE;
    end
    if (m_show && ns == M_PLAY && bus.note_present != 0) push(2, int'(bus.note_present));
    if (tick) push(0, m_row);
    if (done) push(1, 0);
    m_show = tick;
    m_st   = ns;
  endtask

  task automatic advance();
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, input string name);
    int n;
    n = 0;
    do begin
      advance();
      n++;
    end while (!bus.row_tick && n < limit);
    chk(bus.row_tick == 1'b1, name, bus.row_tick, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.row_tick) begin
        if (tick_q.size() == 0) chk(1'b0, "row_tick_unexpected", 1, 0);
        else begin
          mon_ev = tick_q.pop_front();
          chk(mon_ev.cyc == cyc, "row_tick_cycle", cyc, mon_ev.cyc);
          chk(int'(bus.row) == mon_ev.val, "row_tick_row", bus.row, mon_ev.val);
        end
      end
      if (bus.phrase_done) begin
        if (done_q.size() == 0) chk(1'b0, "phrase_done_unexpected", 1, 0);
        else begin
          mon_ev = done_q.pop_front();
          chk(mon_ev.cyc == cyc, "phrase_done_cycle", cyc, mon_ev.cyc);
        end
      end
      if (bus.note_trigger != '0) begin
        if (trig_q.size() == 0) chk(1'b0, "note_trigger_unexpected", bus.note_trigger, 0);
        else begin
          mon_ev = trig_q.pop_front();
          chk(mon_ev.cyc == cyc, "note_trigger_cycle", cyc, mon_ev.cyc);
          chk(int'(bus.note_trigger) == mon_ev.val, "note_trigger_value", bus.note_trigger, mon_ev.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks_seen;
    int resume_edge;
    tempos[0] = 8'd0;   tempos[1] = 8'd120; tempos[2] = 8'd240;
    tempos[3] = 8'd255; tempos[4] = 8'd37;
    bus.play_enable = 0; bus.loop_enable = 0; bus.restart = 0;
    bus.tempo = 0; bus.last_row = 0; bus.note_present = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk(bus.row == 0, "reset_row", bus.row, 0);
    chk(bus.row_tick == 0, "reset_row_tick", bus.row_tick, 0);
    chk(bus.note_trigger == 0, "reset_note_trigger", bus.note_trigger, 0);
    chk(bus.playing == 0, "reset_playing", bus.playing, 0);
    chk(bus.phrase_done == 0, "reset_phrase_done", bus.phrase_done, 0);
    rst_n = 1'b1;

    // Looping 4-row phrase at 120 BPM.
    bus.loop_enable = 1; bus.tempo = 8'd120; bus.last_row = 4'd3; bus.play_enable = 1;
    for (int i = 0; i < 700; i++) begin
      bus.note_present = 4'($urandom);
      advance();
    end
    chk(bus.playing == 1, "loop_still_playing", bus.playing, 1);

    // Non-looping: stop at last row, then re-raise play.
    bus.loop_enable = 0;
    for (int i = 0; i < 700 && bus.playing; i++) advance();
    chk(bus.playing == 0, "done_reached", bus.playing, 0);
    repeat (130) advance();
    chk(bus.row == 3, "done_row_held", bus.row, 3);
    bus.play_enable = 0;
    repeat (2) advance();
    bus.play_enable = 1;
    advance();
    chk(bus.row == 0, "replay_row", bus.row, 0);
    chk(bus.row_tick == 1, "replay_row_tick", bus.row_tick, 1);

    // Pause 60 clocks after a tick, resume after 500.
    bus.last_row = 4'd15; bus.loop_enable = 1;
    wait_tick(200, "pause_pre_tick");
    repeat (60) begin bus.note_present = 4'($urandom); advance(); end
    bus.play_enable = 0;
    ticks_seen = 0;
    repeat (500) begin advance(); if (bus.row_tick) ticks_seen++; end
    chk(ticks_seen == 0, "paused_no_ticks", ticks_seen, 0);
    bus.play_enable = 1;
    resume_edge = cyc + 1;
    advance();
    chk(bus.row_tick == 0, "resume_no_immediate_tick", bus.row_tick, 1'b0);
    wait_tick(200, "resume_tick");
    chk(cyc - resume_edge == 65, "resume_gap", cyc - resume_edge, 65);

    // Restart coinciding with the step out of row 2.
    bus.restart = 1; advance(); bus.restart = 0;
    wait_tick(200, "row1_tick");
    wait_tick(200, "row2_tick");
    chk(bus.row == 2, "at_row2", bus.row, 2);
    repeat (124) advance();
    bus.restart = 1; advance(); bus.restart = 0;
    chk(bus.row == 0, "restart_row", bus.row, 0);
    chk(bus.row_tick == 1, "restart_tick", bus.row_tick, 1);
    advance();
    chk(bus.row_tick == 0, "restart_single_tick", bus.row_tick, 0);
    bus.tempo = 8'd0;
    ticks_seen = 0;
    repeat (1000) begin advance(); if (bus.row_tick) ticks_seen++; end
    chk(ticks_seen == 0, "tempo0_no_ticks", ticks_seen, 0);

    // Directed note trigger.
    bus.tempo = 8'd120; bus.note_present = 4'b0000;
    wait_tick(200, "note_tick");
    bus.note_present = 4'b1010;
    advance();
    chk(bus.note_trigger == 4'b1010, "note_trigger_1010", bus.note_trigger, 4'b1010);
    bus.note_present = 4'b0000;
    advance();
    chk(bus.note_trigger == 4'b0000, "note_trigger_one_cycle", bus.note_trigger, 0);

    // Asynchronous reset mid-playing at row 5.
    bus.tempo = 8'd240; bus.last_row = 4'd7;
    bus.restart = 1; advance(); bus.restart = 0;
    for (int i = 0; i < 8 && bus.row != 5; i++) wait_tick(200, "to_row5_tick");
    chk(bus.row == 5, "reached_row5", bus.row, 5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk(bus.row == 0, "async_reset_row", bus.row, 0);
    chk(bus.playing == 0, "async_reset_playing", bus.playing, 0);
    chk(bus.row_tick == 0, "async_reset_row_tick", bus.row_tick, 0);
    chk(bus.note_trigger == 0, "async_reset_note_trigger", bus.note_trigger, 0);
    @(negedge clk);
    bus.play_enable = 0;
    rst_n = 1'b1;
    repeat (3) advance();
    chk(bus.playing == 0, "post_reset_idle", bus.playing, 0);

    // Randomised control traffic.
    for (int i = 0; i < 3000; i++) begin
      if (bus.play_enable) begin
        if ($urandom_range(99) < 1) bus.play_enable = 0;
      end else if ($urandom_range(99) < 6) bus.play_enable = 1;
      bus.restart = ($urandom_range(199) == 0);
      if ($urandom_range(99) < 2) bus.loop_enable = 1'($urandom);
      if ($urandom_range(99) < 2) bus.tempo = tempos[$urandom_range(4)];
      if ($urandom_range(99) < 2) bus.last_row = 4'($urandom_range(15));
      bus.note_present = 4'($urandom);
      advance();
    end

    bus.restart = 0; bus.play_enable = 0;
    repeat (4) advance();
    chk(tick_q.size() == 0, "tick_queue_drained", tick_q.size(), 0);
    chk(done_q.size() == 0, "done_queue_drained", done_q.size(), 0);
    chk(trig_q.size() == 0, "trig_queue_drained", trig_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
